// File: rtl/trust_out_arbiter_pkg.sv
// Shared definitions for the mesh router switch allocator: port indices,
// crossbar idle select, allocator states and trust field width.
package trust_out_arbiter_pkg;

    localparam int TRUST_W = 4;
    localparam int SEL_W   = 3;

    localparam logic [SEL_W-1:0] P_E = 3'd0;
    localparam logic [SEL_W-1:0] P_W = 3'd1;
    localparam logic [SEL_W-1:0] P_N = 3'd2;
    localparam logic [SEL_W-1:0] P_S = 3'd3;
    localparam logic [SEL_W-1:0] P_T = 3'd4;

    localparam logic [SEL_W-1:0] SEL_IDLE = 3'b111;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } arb_state_e;

    // Next round-robin start after index v among n ports.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v, input int n);
        logic [SEL_W-1:0] r;
        r = (int'(v) >= n - 1) ? P_E : v + 3'd1;
        return r;
    endfunction

endpackage

// File: rtl/trust_out_arbiter_if.sv
// Per-output allocator bundle: input-side request/flit-type/trust vectors and
// the grant, crossbar select and transfer strobe returned to the inputs.
interface trust_out_arbiter_if
    import trust_out_arbiter_pkg::*;
#(
    parameter int NPORT = 5
) ();

    logic [NPORT-1:0]         req;
    logic [NPORT-1:0]         head;
    logic [NPORT-1:0]         tail;
    logic [TRUST_W*NPORT-1:0] trust;
    logic [NPORT-1:0]         gnt;
    logic [SEL_W-1:0]         sel;
    logic                     xfer;

    modport master (
        output req, head, tail, trust,
        input  gnt, sel, xfer
    );

    modport slave (
        input  req, head, tail, trust,
        output gnt, sel, xfer
    );

endinterface

// File: rtl/trust_out_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: searches req_vec from start
// upward with wrap and returns the winner as one-hot and as an index.
module trust_out_arbiter_rr_pick #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req_vec,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    int pos;

    // Walk offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(start) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (req_vec[pos]) begin
                onehot      = '0;
                onehot[pos] = 1'b1;
                idx         = pos[IW-1:0];
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trust_out_arbiter.sv
// Output-port switch allocator: trust-filtered round-robin packet grant held
// head to tail, gated by a downstream credit counter.
module trust_out_arbiter
    import trust_out_arbiter_pkg::*;
#(
    parameter int NPORT     = 5,
    parameter int TRUST_MIN = 8,
    parameter int CREDITS   = 4
) (
    input  logic                 clk1,
    input  logic                 reset,
    trust_out_arbiter_if.slave   bus,
    input  logic                 credit_ret,
    output logic                 busy,
    output logic [2:0]           credit_cnt,
    output logic [7:0]           deny_cnt
);

    localparam logic [TRUST_W-1:0] TRUST_MIN_V = TRUST_W'(TRUST_MIN);
    localparam logic [2:0]         CREDITS_V   = 3'(CREDITS);

    logic [NPORT-1:0] elig;
    logic [NPORT-1:0] low_trust;

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            logic [TRUST_W-1:0] trust_i;
            assign trust_i       = bus.trust[gi*TRUST_W +: TRUST_W];
            assign elig[gi]      = bus.req[gi] & bus.head[gi] & (trust_i >= TRUST_MIN_V);
            assign low_trust[gi] = bus.req[gi] & bus.head[gi] & (trust_i <  TRUST_MIN_V);
        end
    endgenerate

    arb_state_e       state_q,   state_d;
    logic [NPORT-1:0] gnt_q,     gnt_d;
    logic [SEL_W-1:0] sel_q,     sel_d;
    logic             busy_q,    busy_d;
    logic [2:0]       credit_q,  credit_d;
    logic [7:0]       deny_q,    deny_d;
    logic [SEL_W-1:0] rr_ptr_q,  rr_ptr_d;

    logic [NPORT-1:0] pick_oh;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;

    trust_out_arbiter_rr_pick #(
        .N  (NPORT),
        .IW (SEL_W)
    ) u_rr_pick (
        .req_vec (elig),
        .start   (rr_ptr_q),
        .onehot  (pick_oh),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    logic xfer;
    logic owner_tail;

    // The owner is known only through gnt_q, so reduce instead of indexing by sel.
    assign xfer       = !reset && (state_q == ST_ACTIVE) && (|(gnt_q & bus.req))
                        && (credit_q != 3'd0);
    assign owner_tail = |(gnt_q & bus.tail);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        rr_ptr_d = rr_ptr_q;
        credit_d = credit_q;
        deny_d   = deny_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_ACTIVE;
                    gnt_d   = pick_oh;
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (xfer && owner_tail) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    sel_d    = SEL_IDLE;
                    busy_d   = 1'b0;
                    rr_ptr_d = wrap_inc(sel_q, NPORT);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case ({xfer, credit_ret})
            2'b10:   credit_d = credit_q - 3'd1;
            2'b01:   credit_d = (credit_q < CREDITS_V) ? credit_q + 3'd1 : credit_q;
            default: credit_d = credit_q;
        endcase

        // Counted once per idle cycle regardless of how many inputs were masked.
        if ((state_q == ST_IDLE) && (|low_trust) && (deny_q != 8'hFF)) begin
            deny_d = deny_q + 8'd1;
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            sel_q    <= SEL_IDLE;
            busy_q   <= 1'b0;
            rr_ptr_q <= P_E;
            credit_q <= CREDITS_V;
            deny_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            rr_ptr_q <= rr_ptr_d;
            credit_q <= credit_d;
            deny_q   <= deny_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.sel    = sel_q;
    assign bus.xfer   = xfer;
    assign busy       = busy_q;
    assign credit_cnt = credit_q;
    assign deny_cnt   = deny_q;

endmodule
